// File: rtl/posit_extract_arbiter_if.sv
// Handshake bundle between NREQ posit producers, the shared extract stage
// and the downstream posit arithmetic input stage.
interface posit_extract_arbiter_if #(
    parameter int NBITS  = 32,
    parameter int ES     = 3,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int FRAC_W = NBITS - ES - 3
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*NBITS-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDW-1:0]        out_id;
    logic                  out_sign;
    logic                  out_zero;
    logic                  out_inf;
    logic [7:0]            out_scale;
    logic [FRAC_W-1:0]     out_fraction;

    // Producers and the downstream consumer together form the master side.
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_id, out_sign, out_zero, out_inf,
               out_scale, out_fraction
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_id, out_sign, out_zero, out_inf,
               out_scale, out_fraction
    );
endinterface

// File: rtl/posit_extract_arbiter.sv
// Round-robin arbiter feeding one shared posit field decoder; the decoded
// fields and requester id sit in a single output register with valid/ready.
module posit_extract_arbiter #(
    parameter int NBITS  = 32,
    parameter int ES     = 3,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int FRAC_W = NBITS - ES - 3
) (
    input  logic                    clk,
    input  logic                    reset,
    posit_extract_arbiter_if.slave  bus
);
    localparam int RUN_W   = $clog2(NBITS) + 1;
    localparam int FIELD_W = ES + FRAC_W;

    logic [IDW-1:0]    rr_ptr_q,   rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [IDW-1:0]    out_id_q,   out_id_d;
    logic              out_sign_q, out_sign_d;
    logic              out_zero_q, out_zero_d;
    logic              out_inf_q,  out_inf_d;
    logic [7:0]        out_scale_q, out_scale_d;
    logic [FRAC_W-1:0] out_frac_q, out_frac_d;

    logic              can_accept, grant_found, xfer;
    logic [IDW-1:0]    grant_idx;
    logic [IDW:0]      scan_sum;
    logic [NREQ-1:0]   req_ready;
    logic [NBITS-1:0]  sel_word;

    // Grant: first valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int j = 0; j < NREQ; j++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(j);
            if (scan_sum >= (IDW+1)'(NREQ))
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            if (!grant_found && bus.req_valid[scan_sum[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[IDW-1:0];
            end
        end

        can_accept = ~out_valid_q | bus.out_ready;
        xfer       = can_accept & grant_found & ~reset;
        req_ready  = '0;
        if (xfer)
            req_ready[grant_idx] = 1'b1;

        sel_word = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant_idx == IDW'(i))
                sel_word = bus.req_data[i*NBITS +: NBITS];
    end

    logic              dec_sign, dec_zero, dec_inf;
    logic [NBITS-1:0]  dec_u;
    logic              dec_run_bit, dec_run_done;
    logic [RUN_W-1:0]  dec_run_len;
    logic [RUN_W:0]    dec_shamt;
    logic [FIELD_W-1:0] dec_field;
    logic [7:0]        dec_k, dec_scale;

    always_comb begin
        dec_sign     = sel_word[NBITS-1];
        dec_zero     = (sel_word == '0);
        dec_inf      = (sel_word == {1'b1, {(NBITS-1){1'b0}}});
        dec_u        = dec_sign ? (~sel_word + 1'b1) : sel_word;

        // Regime: run of identical bits just below the sign position.
        dec_run_bit  = dec_u[NBITS-2];
        dec_run_len  = '0;
        dec_run_done = 1'b0;
        for (int b = NBITS - 2; b >= 0; b--) begin
            if (!dec_run_done) begin
                if (dec_u[b] == dec_run_bit)
                    dec_run_len = dec_run_len + 1'b1;
                else
                    dec_run_done = 1'b1;
            end
        end

        // Drop sign plus regime (run + terminator); keep the top ES+FRAC_W bits.
        dec_shamt = {1'b0, dec_run_len} + (RUN_W+1)'(2);
        dec_field = FIELD_W'((dec_u << dec_shamt) >> (NBITS - FIELD_W));
        dec_k     = dec_run_bit ? (8'(dec_run_len) - 8'd1) : (8'd0 - 8'(dec_run_len));
        dec_scale = (dec_k << ES) + 8'(dec_field[FIELD_W-1 -: ES]);
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = xfer | (out_valid_q & ~bus.out_ready);
        out_id_d    = out_id_q;
        out_sign_d  = out_sign_q;
        out_zero_d  = out_zero_q;
        out_inf_d   = out_inf_q;
        out_scale_d = out_scale_q;
        out_frac_d  = out_frac_q;
        if (xfer) begin
            rr_ptr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            out_id_d    = grant_idx;
            out_sign_d  = dec_sign;
            out_zero_d  = dec_zero;
            out_inf_d   = dec_inf;
            out_scale_d = dec_scale;
            out_frac_d  = dec_field[FRAC_W-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_sign_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_inf_q   <= 1'b0;
            out_scale_q <= '0;
            out_frac_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_sign_q  <= out_sign_d;
            out_zero_q  <= out_zero_d;
            out_inf_q   <= out_inf_d;
            out_scale_q <= out_scale_d;
            out_frac_q  <= out_frac_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_id       = out_id_q;
    assign bus.out_sign     = out_sign_q;
    assign bus.out_zero     = out_zero_q;
    assign bus.out_inf      = out_inf_q;
    assign bus.out_scale    = out_scale_q;
    assign bus.out_fraction = out_frac_q;
endmodule

// File: tb/tb_posit_extract_arbiter.sv
// Self-checking bench: directed cases plus random traffic against a
// behavioural model of the arbiter and posit field extraction.
module tb_posit_extract_arbiter;
    localparam int NBITS  = 32;
    localparam int ES     = 3;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int FRAC_W = NBITS - ES - 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    posit_extract_arbiter_if #(.NBITS(NBITS), .ES(ES), .NREQ(NREQ), .IDW(IDW), .FRAC_W(FRAC_W)) bif ();

    posit_extract_arbiter #(.NBITS(NBITS), .ES(ES), .NREQ(NREQ), .IDW(IDW), .FRAC_W(FRAC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model of the output register and round-robin pointer.
    logic              m_valid;
    int                m_id;
    int                m_ptr;
    logic              m_sign, m_zero, m_inf;
    logic [7:0]        m_scale;
    logic [FRAC_W-1:0] m_frac;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Arithmetic posit decode: count the regime run, then split the tail.
    function automatic void ref_decode(input logic [NBITS-1:0] w,
                                       output logic sign, output logic zero, output logic inf,
                                       output logic [7:0] scale, output logic [FRAC_W-1:0] frac);
        longint u, tail, f;
        int     first, m, pos, k, bits_left, fb, e;
        zero = (w == 0);
        inf  = (longint'(w) == (longint'(1) << (NBITS - 1)));
        sign = w[NBITS-1];
        u    = longint'(w);
        if (sign) u = ((longint'(1) << NBITS) - u) & ((longint'(1) << NBITS) - 1);
        first = int'((u >> (NBITS - 2)) & 1);
        m   = 0;
        pos = NBITS - 2;
        while (pos >= 0 && int'((u >> pos) & 1) == first) begin
            m++;
            pos--;
        end
        k = (first == 1) ? m - 1 : -m;
        bits_left = NBITS - 1 - (m + 1);
        if (bits_left < 0) bits_left = 0;
        tail = u & ((longint'(1) << bits_left) - 1);
        if (bits_left >= ES) begin
            fb   = bits_left - ES;
            e    = int'(tail >> fb);
            f    = tail & ((longint'(1) << fb) - 1);
            frac = FRAC_W'(f << (FRAC_W - fb));
        end else begin
            e    = int'(tail << (ES - bits_left));
            frac = '0;
        end
        scale = 8'(k * (1 << ES) + e);
    endfunction

    function automatic int ref_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int j = 0; j < NREQ; j++)
            if (v[(ptr + j) % NREQ]) return (ptr + j) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_id = 0; m_ptr = 0;
        m_sign = 1'b0; m_zero = 1'b0; m_inf = 1'b0; m_scale = '0; m_frac = '0;
    endtask

    task automatic check_outputs();
        int              g;
        logic [NREQ-1:0] er;
        g  = ref_grant(bif.req_valid, m_ptr);
        er = '0;
        if (!reset && (!m_valid || bif.out_ready) && g >= 0) er[g] = 1'b1;
        check("req_ready", bif.req_ready, er);
        check("out_valid", bif.out_valid, m_valid);
        if (m_valid) begin
            check("out_id", bif.out_id, m_id);
            check("out_sign", bif.out_sign, m_sign);
            check("out_zero", bif.out_zero, m_zero);
            check("out_inf", bif.out_inf, m_inf);
            if (!m_zero && !m_inf) begin
                check("out_scale", bif.out_scale, m_scale);
                check("out_fraction", bif.out_fraction, m_frac);
            end
        end
    endtask

    task automatic model_update();
        int g;
        if (reset) begin
            model_reset();
            return;
        end
        g = ref_grant(bif.req_valid, m_ptr);
        if ((!m_valid || bif.out_ready) && g >= 0) begin
            ref_decode(bif.req_data[g*NBITS +: NBITS], m_sign, m_zero, m_inf, m_scale, m_frac);
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
            m_valid = 1'b1;
        end else if (m_valid && bif.out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Inputs are driven at posedge+1; checks and model step happen at negedge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic one_shot(input logic [NBITS-1:0] w);
        bif.req_valid = 4'b0001;
        bif.req_data  = '0;
        bif.req_data[NBITS-1:0] = w;
        bif.out_ready = 1'b1;
        cycle();
        bif.req_valid = '0;
    endtask

    logic [NBITS-1:0] specials [6] = '{32'h0000_0000, 32'h8000_0000, 32'h4000_0000,
                                       32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};

    initial begin
        reset = 1'b1;
        bif.req_valid = '0;
        bif.req_data  = '0;
        bif.out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        bif.req_valid = 4'b1111;
        #1;
        check("rst_req_ready", bif.req_ready, 4'b0000);
        check("rst_out_valid", bif.out_valid, 1'b0);
        check("rst_out_id", bif.out_id, 0);
        check("rst_out_scale", bif.out_scale, 8'h00);
        check("rst_out_fraction", bif.out_fraction, 0);
        reset = 1'b0;
        bif.req_valid = '0;
        @(posedge clk);
        #1;

        // Round robin over four always-valid requesters.
        for (int i = 0; i < 4; i++)
            bif.req_data[i*NBITS +: NBITS] = $urandom;
        bif.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("rr_valid", bif.out_valid, 1'b1);
            check("rr_id", bif.out_id, i % NREQ);
        end
        bif.req_valid = '0;
        cycle();

        one_shot(32'h4000_0000);
        check("p40_id", bif.out_id, 0);
        check("p40_sign", bif.out_sign, 1'b0);
        check("p40_zero", bif.out_zero, 1'b0);
        check("p40_inf", bif.out_inf, 1'b0);
        check("p40_scale", bif.out_scale, 8'h00);
        check("p40_fraction", bif.out_fraction, 0);
        one_shot(32'h6000_0000);
        check("p60_scale", bif.out_scale, 8'h08);
        one_shot(32'h2000_0000);
        check("p20_scale", bif.out_scale, 8'hF8);
        one_shot(32'h0000_0000);
        check("p00_zero", bif.out_zero, 1'b1);
        one_shot(32'h8000_0000);
        check("p80_inf", bif.out_inf, 1'b1);
        one_shot(32'hC000_0000);
        check("pC0_sign", bif.out_sign, 1'b1);
        check("pC0_scale", bif.out_scale, 8'h00);
        cycle();

        // Backpressure: hold the register, then release into a same-cycle reload.
        bif.req_valid = 4'b1111;
        cycle();
        bif.out_ready = 1'b0;
        repeat (5) cycle();
        check("bp_held_valid", bif.out_valid, 1'b1);
        bif.out_ready = 1'b1;
        cycle();
        check("bp_reload_valid", bif.out_valid, 1'b1);
        bif.req_valid = '0;
        cycle();

        // Pointer at 2 with requesters 1 and 3 pending.
        bif.req_valid = 4'b0010;
        cycle();
        check("ptr_after_1", dut.rr_ptr_q, 2);
        bif.req_valid = 4'b1010;
        cycle();
        check("skip_id3", bif.out_id, 3);
        cycle();
        check("wrap_id1", bif.out_id, 1);
        check("ptr_end", dut.rr_ptr_q, 2);

        // Asynchronous reset while a result is held.
        bif.req_valid = 4'b1111;
        cycle();
        #1;
        reset = 1'b1;
        #1;
        check("async_out_valid", bif.out_valid, 1'b0);
        check("async_ptr", dut.rr_ptr_q, 0);
        model_reset();
        cycle();
        reset = 1'b0;
        cycle();
        check("post_rst_id", bif.out_id, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bif.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                bif.req_data[i*NBITS +: NBITS] = ($urandom_range(0, 3) == 0) ?
                                                 specials[$urandom_range(0, 5)] : $urandom;
            bif.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
